// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the issue-side hazard scoreboard.
package hazard_pkg;

  localparam int REG_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic                 valid;
    logic [REG_W_DEF-1:0] dest;
    logic                 wb_en;
    logic                 mem_r_en;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE_REC = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request, pipeline control and shadow-state bus.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic             freeze;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] id_dest;
  logic             id_wb_en;
  logic             id_mem_r_en;
  logic             hazard;
  logic [REG_W-1:0] exe_dest;
  logic [REG_W-1:0] mem_dest;
  logic [REG_W-1:0] wb_dest;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             wb_wb_en;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output freeze, flush, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en,
    input  hazard, exe_dest, mem_dest, wb_dest,
           exe_wb_en, mem_wb_en, wb_wb_en, stall_count
  );

  modport slave (
    input  freeze, flush, id_valid, id_src1, id_src2, id_two_src,
           id_dest, id_wb_en, id_mem_r_en,
    output hazard, exe_dest, mem_dest, wb_dest,
           exe_wb_en, mem_wb_en, wb_wb_en, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - hazard_match: compares one shadow stage record against the ID sources.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  stage_rec_t       rec,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  output logic             match,
  output logic             load_match
);
  logic hit;

  assign hit        = (rec.dest == src1) | (two_src & (rec.dest == src2));
  assign match      = rec.valid & rec.wb_en & hit;
  assign load_match = match & rec.mem_r_en;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow EXE/MEM/WB destination tracker and ID stall decision.
// Define HAZARD_FWD_EN when a forwarding unit exists: only load-use then stalls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);
  // Record dest width comes from the package; REG_W must equal REG_W_DEF.
  stage_rec_t       exe_q;
  stage_rec_t       mem_q;
  stage_rec_t       wb_q;
  stage_rec_t       id_rec;
  logic [CNT_W-1:0] cnt_q;
  logic             exe_match;
  logic             exe_load;
  logic             mem_match;
  logic             mem_load;
  logic             stall_cond;
  logic             hazard;
  logic             issue;
  logic             unused_ok;

  hazard_match #(.REG_W(REG_W)) u_exe_match (
    .rec        (exe_q),
    .src1       (bus.id_src1),
    .src2       (bus.id_src2),
    .two_src    (bus.id_two_src),
    .match      (exe_match),
    .load_match (exe_load)
  );

  hazard_match #(.REG_W(REG_W)) u_mem_match (
    .rec        (mem_q),
    .src1       (bus.id_src1),
    .src2       (bus.id_src2),
    .two_src    (bus.id_two_src),
    .match      (mem_match),
    .load_match (mem_load)
  );

  // WB is never checked: the register file writes before ID reads.
`ifdef HAZARD_FWD_EN
  assign stall_cond = exe_load;
`else
  assign stall_cond = exe_match | mem_match;
`endif

  assign hazard = bus.id_valid & ~bus.flush & stall_cond;
  assign issue  = bus.id_valid & ~hazard & ~bus.flush;

  always_comb begin
    id_rec = BUBBLE_REC;
    if (issue) begin
      id_rec.valid    = 1'b1;
      id_rec.dest     = bus.id_dest;
      id_rec.wb_en    = bus.id_wb_en;
      id_rec.mem_r_en = bus.id_mem_r_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= BUBBLE_REC;
      mem_q <= BUBBLE_REC;
      wb_q  <= BUBBLE_REC;
      cnt_q <= '0;
    end else if (!bus.freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= id_rec;
      if (hazard && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.hazard      = hazard;
  assign bus.exe_dest    = exe_q.dest;
  assign bus.mem_dest    = mem_q.dest;
  assign bus.wb_dest     = wb_q.dest;
  assign bus.exe_wb_en   = exe_q.wb_en;
  assign bus.mem_wb_en   = mem_q.wb_en;
  assign bus.wb_wb_en    = wb_q.wb_en;
  assign bus.stall_count = cnt_q;

  assign unused_ok = ^{exe_match, exe_load, mem_match, mem_load, wb_q.valid, wb_q.mem_r_en};

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Issue-side companion to the EXE-stage forwarding unit in the 5-stage ARM-subset pipeline.
- Tracks in-flight destination registers in the EXE, MEM and WB stages with its own shadow pipeline.
- Decides combinationally whether the instruction in ID must stall.
- Inserts a bubble record into its shadow EXE slot whenever ID is stalled or flushed.

Parameters:
- REG_W, 4, register index width (16 architectural registers).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  global pipeline hold (memory wait); shadow pipeline and counter hold.
- flush  in  1  branch taken; the instruction in ID is discarded.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  REG_W  first source register (always read when id_valid).
- id_src2  in  REG_W  second source register.
- id_two_src  in  1  id_src2 is actually read.
- id_dest  in  REG_W  destination of the ID instruction.
- id_wb_en  in  1  ID instruction writes id_dest.
- id_mem_r_en  in  1  ID instruction is a load.
- hazard  out  1  stall ID/IF this cycle (combinational).
- exe_dest, mem_dest, wb_dest  out  REG_W  shadow destinations, for debug and for forwarding cross-check.
- exe_wb_en, mem_wb_en, wb_wb_en  out  1  shadow write enables.
- stall_count  out  CNT_W  number of cycles hazard=1 while freeze=0.

Behaviour:
- Shadow record per stage: {valid, dest, wb_en, mem_r_en}. Stages are EXE, MEM, WB.
- Reset (async, rst=1): all records cleared (valid=0, dest=0, wb_en=0, mem_r_en=0); stall_count=0; therefore hazard=0 while rst is held.
- Match for stage S: S.valid & S.wb_en & (S.dest==id_src1 | (id_two_src & S.dest==id_src2)).
- hazard = id_valid & ~flush & (stall condition; see Optional Feature).
- WB-stage matches never stall: the register file writes on the falling edge (write-before-read).
- Update on posedge clk when freeze=0:
  - WB <= MEM; MEM <= EXE.
  - EXE <= ID record if id_valid & ~hazard & ~flush, otherwise a bubble (all fields 0).
- freeze=1: every record and stall_count hold; hazard is still driven combinationally from the current state.
- flush and hazard conditions in the same cycle: flush wins, hazard=0, bubble inserted.
- id_wb_en=0: the record enters EXE with wb_en=0, so it can never cause a match.
- stall_count increments when hazard=1 & freeze=0 and saturates at all-ones (no wrap).
- No dependency on src==dest equality within a single instruction; an instruction never stalls on itself.
- Latency: the shadow pipeline advances exactly one stage per unfrozen cycle, matching the datapath pipeline registers.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined (forwarding present): stall only on load-use, i.e. EXE match with EXE.mem_r_en=1. All other EXE/MEM matches are resolved by the forwarding unit; a load-use costs exactly 1 stall cycle.
- Undefined (no forwarding): stall on any EXE or MEM match. A dependent instruction directly behind its producer stalls 2 cycles.

Decomposition:
- Shared package hazard_pkg:
  - typedef stage_rec_t {valid, dest[REG_W], wb_en, mem_r_en};
  - constant BUBBLE_REC (all zero);
  - constants REG_W_DEF=4, CNT_W_DEF=16.
- One natural sub-module, hazard_match: combinational compare of one stage_rec_t against src1/src2/two_src, returning match and load_match. Instantiated for EXE and MEM.

Test Plan:
- Reset: assert rst mid-stream with a load in EXE -> immediately hazard=0, all shadow outputs 0, stall_count=0.
- Load-use (HAZARD_FWD_EN):
  - Stimulus: LDR r3 issued, next ID src1=3.
  - Response: hazard=1 for exactly 1 cycle, then EXE holds a bubble and the dependent instruction issues; stall_count=1.
- Dependent ALU op, no forwarding (macro undefined):
  - Stimulus: ADD r2 then SUB with src2=2, two_src=1.
  - Response: hazard=1 for 2 cycles; with two_src=0 the same sequence gives hazard=0.
- Freeze: hold freeze=1 for 3 cycles during a load-use stall -> records unchanged, stall_count unchanged, hazard stays 1; resumes correctly after release.
- Flush priority: flush=1 with a matching load in EXE -> hazard=0 and a bubble enters EXE on the next edge.
- Saturation: force 65540 hazard cycles -> stall_count=16'hFFFF and holds.
